// File: rtl/red_rr_scheduler_pkg.sv
// Shared definitions for the reduction scheduler: opcode encodings, FSM state
// type and the illegal-opcode test used by the reduction datapath.
package red_rr_scheduler_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;

  // Opcodes 110 and 111 are the only illegal ones: both upper bits set.
  localparam logic [2:0] OP_ILLEGAL_MASK = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_EXEC   = 2'b01,
    S_RESULT = 2'b10
  } state_e;

  function automatic logic op_illegal(input logic [2:0] op);
    return (op & OP_ILLEGAL_MASK) == OP_ILLEGAL_MASK;
  endfunction

endpackage

// File: rtl/red_rr_scheduler_red_unit.sv
// red_unit: combinational reduction of a WIDTH-bit word.
//   op      in  3      reduction opcode
//   data    in  WIDTH  operand word
//   res_bit out 1      reduction result (0 for illegal opcodes)
//   res_err out 1      opcode illegal
module red_unit
  import red_rr_scheduler_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data,
  output logic             res_bit,
  output logic             res_err
);

  always_comb begin
    res_bit = 1'b0;
    res_err = op_illegal(op);
    case (op)
      OP_AND:  res_bit = &data;
      OP_OR:   res_bit = |data;
      OP_XOR:  res_bit = ^data;
      OP_NAND: res_bit = ~&data;
      OP_NOR:  res_bit = ~|data;
      OP_XNOR: res_bit = ~^data;
      default: res_bit = 1'b0;
    endcase
  end

endmodule

// File: rtl/red_rr_scheduler.sv
// red_rr_scheduler: round-robin sharing of one reduction unit among NREQ
// requesters. Grants one requester per transaction, latches its opcode/word,
// and returns a registered, ID-tagged result over a valid/ready port.
//   clk, rst_n   clock, asynchronous active-low reset
//   req          per-requester request
//   req_op       3-bit opcode per requester, slice i = [3i+2:3i]
//   req_data     WIDTH-bit word per requester
//   gnt          registered one-hot grant, one cycle wide
//   res_valid    result valid; res_ready consumer ready
//   res_bit      reduction result; res_id owner; res_err illegal opcode
module red_rr_scheduler
  import red_rr_scheduler_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_bit,
  output logic [IDW-1:0]        res_id,
  output logic                  res_err
);

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [IDW-1:0]     id_q, id_d;
  logic               res_valid_q, res_valid_d;
  logic               res_bit_q, res_bit_d;
  logic [IDW-1:0]     res_id_q, res_id_d;
  logic               res_err_q, res_err_d;

  logic               arb_found;
  logic [IDW-1:0]     arb_idx;
  logic [NREQ-1:0]    arb_onehot;
  logic [2:0]         arb_op;
  logic [WIDTH-1:0]   arb_data;
  logic [IDW-1:0]     ptr_next;
  logic               red_bit, red_err;
  logic               take_grant;

  // Rotating priority search starting at ptr; the first set req wins and its
  // operands are selected in the same pass.
  always_comb begin
    int unsigned cand;
    cand       = 0;
    arb_found  = 1'b0;
    arb_idx    = '0;
    arb_onehot = '0;
    arb_op     = '0;
    arb_data   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(ptr_q) + i) % NREQ;
      if (!arb_found && req[cand]) begin
        arb_found        = 1'b1;
        arb_idx          = IDW'(cand);
        arb_onehot[cand] = 1'b1;
        arb_op           = req_op[3*cand +: 3];
        arb_data         = req_data[WIDTH*cand +: WIDTH];
      end
    end
  end

  assign ptr_next = (arb_idx == IDW'(NREQ-1)) ? '0 : arb_idx + IDW'(1);

  red_unit #(.WIDTH(WIDTH)) u_red_unit (
    .op      (op_q),
    .data    (data_q),
    .res_bit (red_bit),
    .res_err (red_err)
  );

  // IDLE and an accepted RESULT share the grant path, which gives
  // back-to-back service without an intermediate IDLE cycle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    op_d        = op_q;
    data_d      = data_q;
    id_d        = id_q;
    res_valid_d = res_valid_q;
    res_bit_d   = res_bit_q;
    res_id_d    = res_id_q;
    res_err_d   = res_err_q;
    take_grant  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arb_found) take_grant = 1'b1;
      end
      S_EXEC: begin
        res_bit_d   = red_bit;
        res_err_d   = red_err;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = S_RESULT;
      end
      S_RESULT: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          if (arb_found) take_grant = 1'b1;
          else           state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take_grant) begin
      gnt_d   = arb_onehot;
      op_d    = arb_op;
      data_d  = arb_data;
      id_d    = arb_idx;
      ptr_d   = ptr_next;
      state_d = S_EXEC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      op_q        <= '0;
      data_q      <= '0;
      id_q        <= '0;
      res_valid_q <= 1'b0;
      res_bit_q   <= 1'b0;
      res_id_q    <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      op_q        <= op_d;
      data_q      <= data_d;
      id_q        <= id_d;
      res_valid_q <= res_valid_d;
      res_bit_q   <= res_bit_d;
      res_id_q    <= res_id_d;
      res_err_q   <= res_err_d;
    end
  end

  assign gnt       = gnt_q;
  assign res_valid = res_valid_q;
  assign res_bit   = res_bit_q;
  assign res_id    = res_id_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_red_rr_scheduler.sv
// Directed bench for red_rr_scheduler: reset, latency, round-robin order,
// backpressure, illegal opcodes and a full opcode sweep.
module tb_red_rr_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] req_op;
  logic [15:0] req_data;
  logic [3:0]  gnt;
  logic        res_valid;
  logic        res_ready;
  logic        res_bit;
  logic [1:0]  res_id;
  logic        res_err;

  int tests  = 0;
  int failed = 0;

  red_rr_scheduler #(.NREQ(4), .WIDTH(4), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_op    (req_op),
    .req_data  (req_data),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_bit   (res_bit),
    .res_id    (res_id),
    .res_err   (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [3:0] d);
    req_op[3*i +: 3]   = op;
    req_data[4*i +: 4] = d;
  endtask

  function automatic logic ref_reduce(input logic [2:0] op, input logic [3:0] d);
    case (op)
      3'b000:  return &d;
      3'b001:  return |d;
      3'b010:  return ^d;
      3'b011:  return ~&d;
      3'b100:  return ~|d;
      3'b101:  return ~^d;
      default: return 1'b0;
    endcase
  endfunction

  logic [3:0] rr_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] rr_id   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic       rr_bit  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0] sweep_d [4] = '{4'b0000, 4'b1111, 4'b0101, 4'b1101};

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    req_op    = '0;
    req_data  = '0;
    res_ready = 1'b1;
    tick();
    tick();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_valid", res_valid, 1'b0);
    check("rst_bit", res_bit, 1'b0);
    check("rst_id", res_id, 2'd0);
    check("rst_err", res_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single XOR request: latency and result, twice.
    req = 4'b0001; set_req(0, 3'b010, 4'b0101);
    tick();
    check("xor0_gnt", gnt, 4'b0001);
    check("xor0_valid_early", res_valid, 1'b0);
    req = 4'b0000;
    tick();
    check("xor0_gnt_drop", gnt, 4'b0000);
    check("xor0_valid", res_valid, 1'b1);
    check("xor0_bit", res_bit, 1'b0);
    check("xor0_id", res_id, 2'd0);
    tick();
    check("xor0_consumed", res_valid, 1'b0);

    req = 4'b0001; set_req(0, 3'b010, 4'b1101);
    tick();
    check("xor1_gnt", gnt, 4'b0001);
    req = 4'b0000;
    tick();
    check("xor1_valid", res_valid, 1'b1);
    check("xor1_bit", res_bit, 1'b1);
    tick();

    // Illegal op on req3, then back-to-back grant of req1 and reset mid-EXEC.
    req = 4'b1000; set_req(3, 3'b111, 4'b1010);
    tick();
    check("ill_gnt", gnt, 4'b1000);
    req = 4'b0000;
    tick();
    check("ill_valid", res_valid, 1'b1);
    check("ill_err", res_err, 1'b1);
    check("ill_bit", res_bit, 1'b0);
    check("ill_id", res_id, 2'd3);
    req = 4'b0010; set_req(1, 3'b001, 4'b1111);
    tick();
    check("b2b_gnt", gnt, 4'b0010);
    check("b2b_valid", res_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_gnt", gnt, 4'b0000);
    check("arst_valid", res_valid, 1'b0);
    check("arst_bit", res_bit, 1'b0);
    check("arst_id", res_id, 2'd0);
    check("arst_err", res_err, 1'b0);
    req = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("arst_no_result", res_valid, 1'b0);
    check("arst_no_gnt", gnt, 4'b0000);

    // All four requesting, held: round-robin from ptr=0.
    set_req(0, 3'b001, 4'b0000);
    set_req(1, 3'b001, 4'b0001);
    set_req(2, 3'b001, 4'b0000);
    set_req(3, 3'b001, 4'b1000);
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      tick();
      check($sformatf("rr_gnt%0d", j), gnt, rr_gnt[j]);
      tick();
      check($sformatf("rr_gap%0d", j), gnt, 4'b0000);
      check($sformatf("rr_valid%0d", j), res_valid, 1'b1);
      check($sformatf("rr_id%0d", j), res_id, rr_id[j]);
      check($sformatf("rr_bit%0d", j), res_bit, rr_bit[j]);
    end
    req = 4'b0000;
    tick();
    check("rr_idle", res_valid, 1'b0);

    // Backpressure: req2 result held while req1 waits; ptr is 1 here.
    res_ready = 1'b0;
    req = 4'b0100; set_req(2, 3'b000, 4'b1111);
    tick();
    check("bp_gnt2", gnt, 4'b0100);
    req = 4'b0010; set_req(1, 3'b001, 4'b0000);
    tick();
    check("bp_valid0", res_valid, 1'b1);
    for (int j = 0; j < 5; j++) begin
      tick();
      check($sformatf("bp_hold_valid%0d", j), res_valid, 1'b1);
      check($sformatf("bp_hold_bit%0d", j), res_bit, 1'b1);
      check($sformatf("bp_hold_id%0d", j), res_id, 2'd2);
      check($sformatf("bp_no_gnt%0d", j), gnt, 4'b0000);
    end
    res_ready = 1'b1;
    tick();
    check("bp_gnt1", gnt, 4'b0010);
    check("bp_released", res_valid, 1'b0);
    req = 4'b0000;
    tick();
    check("bp_r1_valid", res_valid, 1'b1);
    check("bp_r1_id", res_id, 2'd1);
    check("bp_r1_bit", res_bit, 1'b0);
    tick();

    // req3: illegal 111, then NOR of 0000.
    req = 4'b1000; set_req(3, 3'b111, 4'b1010);
    tick();
    check("r3_gnt_a", gnt, 4'b1000);
    req = 4'b0000;
    tick();
    check("r3_err_a", res_err, 1'b1);
    check("r3_bit_a", res_bit, 1'b0);
    check("r3_id_a", res_id, 2'd3);
    tick();
    req = 4'b1000; set_req(3, 3'b100, 4'b0000);
    tick();
    check("r3_gnt_b", gnt, 4'b1000);
    req = 4'b0000;
    tick();
    check("r3_err_b", res_err, 1'b0);
    check("r3_bit_b", res_bit, 1'b1);
    tick();

    // Opcode sweep on requester 0.
    for (int op = 0; op < 6; op++) begin
      for (int k = 0; k < 4; k++) begin
        req = 4'b0001; set_req(0, 3'(op), sweep_d[k]);
        tick();
        check($sformatf("sw_gnt_op%0d_d%0h", op, sweep_d[k]), gnt, 4'b0001);
        req = 4'b0000;
        tick();
        check($sformatf("sw_bit_op%0d_d%0h", op, sweep_d[k]), res_bit,
              ref_reduce(3'(op), sweep_d[k]));
        check($sformatf("sw_err_op%0d_d%0h", op, sweep_d[k]), res_err, 1'b0);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
